imem_loader: RTL and testbench

//  Write-side companion to the instruction memory. Receives a program as a byte stream over a

---
 rtl/imem_loader_pkg.sv | 35 +++
 rtl/imem_loader_byte_packer.sv | 29 ++
 rtl/imem_loader.sv | 215 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// byte-packing geometry and small helpers used by the loader and its packer.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = 2;

  // Little-endian lane insert: byte k lands in word[8k+7:8k].
  function automatic logic [31:0] pack_byte(input logic [31:0]           word,
                                            input logic [BYTE_IDX_W-1:0] idx,
                                            input logic [7:0]            data);
    logic [31:0] res;
    res = word;
    case (idx)
      2'd0:    res[7:0]   = data;
      2'd1:    res[15:8]  = data;
      2'd2:    res[23:16] = data;
      2'd3:    res[31:24] = data;
      default: res        = word;
    endcase
    return res;
  endfunction

  // A load must cover at least one word and may not exceed the memory.
  function automatic logic count_legal(input int unsigned cnt, input int unsigned depth);
    return (cnt != 32'd0) && (cnt <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles up to four stream bytes into one 32-bit little-endian word register.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            data_byte,
  input  logic [BYTE_IDX_W-1:0] byte_idx,
  input  logic                  load,
  input  logic                  clear,
  output logic [31:0]           word
);

  logic [31:0] word_r;

  // Word register: clear wins over load so a new word always starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_r <= 32'h0000_0000;
    end else if (clear) begin
      word_r <= 32'h0000_0000;
    end else if (load) begin
      word_r <= pack_byte(word_r, byte_idx, data_byte);
    end
  end

  assign word = word_r;

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-wise program into instruction memory one 32-bit word at a
// time and keeps the CPU held in reset until the whole program is written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0]     ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0]     ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]       CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  state_t state_r, state_nxt_s;

  logic                  in_ready_r,   in_ready_nxt_s;
  logic                  imem_we_r,    imem_we_nxt_s;
  logic [ADDR_W-1:0]     imem_addr_r,  imem_addr_nxt_s;
  logic [31:0]           imem_wdata_r, imem_wdata_nxt_s;
  logic                  cpu_hold_r,   cpu_hold_nxt_s;
  logic                  busy_r,       busy_nxt_s;
  logic                  done_r,       done_nxt_s;
  logic                  error_r,      error_nxt_s;
  logic [ADDR_W:0]       count_r,      count_nxt_s;
  logic [ADDR_W-1:0]     word_idx_r,   word_idx_nxt_s;
  logic [BYTE_IDX_W-1:0] byte_idx_r,   byte_idx_nxt_s;

  logic        xfer_s;
  logic        last_byte_s;
  logic        last_word_s;
  logic        start_ok_s;
  logic        pack_load_s;
  logic        pack_clear_s;
  logic [31:0] packed_word_s;

  assign xfer_s      = in_valid && in_ready_r;
  assign last_byte_s = (byte_idx_r == LAST_BYTE);
  assign last_word_s = ({1'b0, word_idx_r} == (count_r - CNT_ONE));
  assign start_ok_s  = count_legal(32'(word_count), 32'(DEPTH));

  imem_loader_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .data_byte (in_byte),
    .byte_idx  (byte_idx_r),
    .load      (pack_load_s),
    .clear     (pack_clear_s),
    .word      (packed_word_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && start_ok_s) begin
          state_nxt_s = ST_RECV;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (xfer_s && last_byte_s) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_RECV;
        end
      end
      ST_WRITE: begin
        if (last_word_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RECV;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, counters and packer controls.
  always_comb begin
    in_ready_nxt_s   = in_ready_r;
    imem_we_nxt_s    = 1'b0;
    imem_addr_nxt_s  = imem_addr_r;
    imem_wdata_nxt_s = imem_wdata_r;
    cpu_hold_nxt_s   = cpu_hold_r;
    busy_nxt_s       = busy_r;
    done_nxt_s       = done_r;
    error_nxt_s      = error_r;
    count_nxt_s      = count_r;
    word_idx_nxt_s   = word_idx_r;
    byte_idx_nxt_s   = byte_idx_r;
    pack_load_s      = 1'b0;
    pack_clear_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready_nxt_s = 1'b0;
        if (start && start_ok_s) begin
          count_nxt_s    = word_count;
          error_nxt_s    = 1'b0;
          done_nxt_s     = 1'b0;
          cpu_hold_nxt_s = 1'b1;
          busy_nxt_s     = 1'b1;
          byte_idx_nxt_s = {BYTE_IDX_W{1'b0}};
          word_idx_nxt_s = ADDR_ZERO;
          in_ready_nxt_s = 1'b1;
          pack_clear_s   = 1'b1;
        end else if (start) begin
          error_nxt_s = 1'b1;
          done_nxt_s  = 1'b0;
        end else begin
          error_nxt_s = error_r;
        end
      end
      ST_RECV: begin
        if (xfer_s) begin
          pack_load_s = 1'b1;
          if (last_byte_s) begin
            // The 4th byte goes straight into the write data; the packer only holds lanes 0..2.
            in_ready_nxt_s   = 1'b0;
            imem_we_nxt_s    = 1'b1;
            imem_addr_nxt_s  = word_idx_r;
            imem_wdata_nxt_s = pack_byte(packed_word_s, byte_idx_r, in_byte);
            byte_idx_nxt_s   = {BYTE_IDX_W{1'b0}};
          end else begin
            byte_idx_nxt_s = byte_idx_r + {{(BYTE_IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          byte_idx_nxt_s = byte_idx_r;
        end
      end
      ST_WRITE: begin
        pack_clear_s = 1'b1;
        if (last_word_s) begin
          in_ready_nxt_s = 1'b0;
          busy_nxt_s     = 1'b0;
          done_nxt_s     = 1'b1;
          cpu_hold_nxt_s = 1'b0;
        end else begin
          in_ready_nxt_s = 1'b1;
          word_idx_nxt_s = word_idx_r + ADDR_ONE;
          byte_idx_nxt_s = {BYTE_IDX_W{1'b0}};
        end
      end
      default: begin
        in_ready_nxt_s = 1'b0;
        busy_nxt_s     = 1'b0;
      end
    endcase
  end

  // Output and counter registers; reset aborts any load without issuing a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_r   <= 1'b0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= ADDR_ZERO;
      imem_wdata_r <= 32'h0000_0000;
      cpu_hold_r   <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      count_r      <= {(ADDR_W+1){1'b0}};
      word_idx_r   <= ADDR_ZERO;
      byte_idx_r   <= {BYTE_IDX_W{1'b0}};
    end else begin
      in_ready_r   <= in_ready_nxt_s;
      imem_we_r    <= imem_we_nxt_s;
      imem_addr_r  <= imem_addr_nxt_s;
      imem_wdata_r <= imem_wdata_nxt_s;
      cpu_hold_r   <= cpu_hold_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
      error_r      <= error_nxt_s;
      count_r      <= count_nxt_s;
      word_idx_r   <= word_idx_nxt_s;
      byte_idx_r   <= byte_idx_nxt_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_hold   = cpu_hold_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected memory writes,
// a monitor pops and compares them on every imem_we pulse.
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic [7:0]        in_byte = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  int pass_cnt = 0;
  int check_cnt = 0;
  int wr_cnt = 0;
  int cyc = 0;
  int last_xfer_cyc = 0;
  logic [37:0] exp_q[$];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  initial begin : monitor
    logic [37:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (imem_we === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check_cnt++;
          $display("FAIL unexpected_write: addr %0d data 0x%08h, no write expected", imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", {26'd0, imem_addr}, {26'd0, e[37:32]});
          check("write_data", imem_wdata, e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", pass_cnt, check_cnt);
    $fatal(1);
  end

  task automatic push_exp(input int a, input logic [31:0] d);
    exp_q.push_back({6'(a), d});
  endtask

  // Called at a negedge; returns at a negedge with start low again.
  task automatic do_start(input logic [ADDR_W:0] cnt);
    start = 1'b1;
    word_count = cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; in_valid is left high on return.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_byte = b;
    in_valid = 1'b1;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      check_cnt++;
      $display("FAIL byte_accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
    end else begin
      @(posedge clk);
      last_xfer_cyc = cyc;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output int done_cyc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    done_cyc = cyc - 1;
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
    check({tag, "_imem_addr"}, {26'd0, imem_addr}, 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    logic [7:0] prog [8];
    logic [7:0] wb [4];
    int first_cyc;
    int done_cyc;
    int wr_base;

    prog = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

    // Reset values
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // Illegal counts are rejected and never write
    do_start(7'd0);
    check("cnt0_error", {31'd0, error}, 32'd1);
    check("cnt0_busy", {31'd0, busy}, 32'd0);
    check("cnt0_in_ready", {31'd0, in_ready}, 32'd0);
    do_start(7'd65);
    check("cnt65_error", {31'd0, error}, 32'd1);
    check("cnt65_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (5) @(negedge clk);
    check("illegal_no_write", 32'(wr_cnt), 32'd0);

    // Two words, in_valid held high
    do_start(7'd2);
    check("t2_busy", {31'd0, busy}, 32'd1);
    check("t2_in_ready", {31'd0, in_ready}, 32'd1);
    check("t2_error_cleared", {31'd0, error}, 32'd0);
    push_exp(0, 32'h00A00513);
    push_exp(1, 32'h00100593);
    first_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      send_byte(prog[i], 0);
      if (i == 0) first_cyc = last_xfer_cyc;
    end
    in_valid = 1'b0;
    wait_done(done_cyc);
    check("t2_done_latency", 32'(done_cyc - first_cyc + 1), 32'd10);
    check("t2_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("t2_busy_end", {31'd0, busy}, 32'd0);
    check("t2_writes", 32'(wr_cnt), 32'd2);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Illegal start after a completed load clears done
    do_start(7'd65);
    check("after_done_error", {31'd0, error}, 32'd1);
    check("after_done_done", {31'd0, done}, 32'd0);
    check("after_done_cpu_hold", {31'd0, cpu_hold}, 32'd0);

    // Same stream with 3 idle cycles before every byte
    wr_base = wr_cnt;
    do_start(7'd2);
    check("t3_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("t3_error", {31'd0, error}, 32'd0);
    push_exp(0, 32'h00A00513);
    push_exp(1, 32'h00100593);
    for (int i = 0; i < 8; i++) send_byte(prog[i], 3);
    in_valid = 1'b0;
    wait_done(done_cyc);
    repeat (3) @(negedge clk);
    check("t3_writes", 32'(wr_cnt - wr_base), 32'd2);
    check("t3_cpu_hold_end", {31'd0, cpu_hold}, 32'd0);

    // Reset in the middle of word 1
    wr_base = wr_cnt;
    do_start(7'd3);
    push_exp(0, 32'h00A00513);
    for (int i = 0; i < 6; i++) send_byte(prog[i], 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_writes_before_reset", 32'(wr_cnt - wr_base), 32'd1);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    do_start(7'd1);
    push_exp(0, 32'h00100593);
    for (int i = 4; i < 8; i++) send_byte(prog[i], 0);
    in_valid = 1'b0;
    wait_done(done_cyc);
    check("t5_writes_total", 32'(wr_cnt - wr_base), 32'd2);
    check("t5_cpu_hold", {31'd0, cpu_hold}, 32'd0);

    // Full depth with a start pulse while busy
    wr_base = wr_cnt;
    do_start(7'd64);
    for (int w = 0; w < 64; w++) begin
      wb[0] = 8'(w);
      wb[1] = ~8'(w);
      wb[2] = 8'h5A;
      wb[3] = 8'(w) + 8'h80;
      push_exp(w, {wb[3], wb[2], wb[1], wb[0]});
      for (int k = 0; k < 4; k++) begin
        send_byte(wb[k], 0);
        start = (w == 3 && k == 1);
        word_count = (w == 3 && k == 1) ? 7'd1 : 7'd64;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    wait_done(done_cyc);
    repeat (3) @(negedge clk);
    check("t6_writes", 32'(wr_cnt - wr_base), 32'd64);
    check("t6_last_addr", {26'd0, imem_addr}, 32'd63);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_error", {31'd0, error}, 32'd0);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
